multicycle_ctrl: RTL and testbench
==================================

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 Parameter: MEM_TIMEOUT, 15, max consecutive cycles a memory state waits on mem_ready before abandoning the access (range 1..255).
REQ-002 Ports:
- clk, in, 1, rising-edge clock.
- rst_n, in, 1, asynchronous active-low reset.
- instr, in, 32, current IR contents; valid from DECODE onward.
- zero, in, 1, ALU zero flag.
- mem_ready, in, 1, memory completes the current read/write this cycle.
- pc_we, out, 1, PC write enable.
- pc_src, out, 2, PC source: 00 ALU result, 01 ALUOut, 10 jump target.
- ir_we, out, 1, IR write enable.
- iord, out, 1, memory address source: 0 PC, 1 ALUOut.
- mem_rd, out, 1, memory read strobe.
- mem_wr, out, 1, memory write strobe.
- reg_we, out, 1, register-file write enable.
- reg_dst, out, 1, destination register: 1 rd, 0 rt.
- mem_to_reg, out, 1, write-back source: 1 MDR, 0 ALUOut.
- alu_src_a, out, 1, ALU A operand: 0 PC, 1 register A.
- alu_src_b, out, 2, ALU B operand: 00 register B, 01 constant 4, 10 extended immediate, 11 extended immediate shifted left 2.
- ext_op, out, 1, immediate extension: 1 sign, 0 zero.
- alu_op, out, 3, ALU operation: 000 add, 100 sub, 001 and, 101 or, 010 xor, 110 lui.
- illegal, out, 1, one-cycle pulse on an unsupported opcode or funct.
- bus_err, out, 1, one-cycle pulse on a memory timeout.
- state, out, 4, current state (debug).

Function
REQ-003 Moore FSM: state register updates on clk; all outputs decode combinationally from state and instr, except where mem_ready or zero gates a signal as stated below.
REQ-004 States and encoding:
- IDLE=0, FETCH=1, DECODE=2, EXE_R=3, EXE_I=4, WB=5.
- MEM_ADDR=6, MEM_RD=7, MEM_WR=8, WB_MEM=9, BRANCH=10, JUMP=11.
REQ-005 Any output not stated for a state is 0 in that state.
REQ-006 IDLE: all outputs 0; next state FETCH unconditionally.
REQ-007 FETCH:
- Drives mem_rd=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=000, pc_src=00.
- ir_we=pc_we=mem_ready; advances to DECODE only when mem_ready=1.
REQ-008 DECODE:
- Drives alu_src_a=0, alu_src_b=11, ext_op=1, alu_op=000 (branch target into ALUOut).
- Dispatch on opcode: 000000 -> EXE_R; 001001 addiu, 001101 ori, 001111 lui -> EXE_I; 100011 lw, 101011 sw -> MEM_ADDR; 000100 beq -> BRANCH; 000010 j -> JUMP.
- Any other opcode -> FETCH with illegal=1 for that cycle.
REQ-009 EXE_R:
- alu_src_a=1, alu_src_b=00.
- funct mapping: 100001 -> 000, 100011 -> 100, 100100 -> 001, 100101 -> 101, 100110 -> 010; next WB.
- Unsupported funct -> FETCH with illegal=1 for that cycle; no register write.
REQ-010 EXE_I: alu_src_a=1, alu_src_b=10.
- addiu: alu_op=000, ext_op=1.
- ori: alu_op=101, ext_op=0.
- lui: alu_op=110, ext_op=0.
- Next state WB.
REQ-011 WB: reg_we=1, mem_to_reg=0, reg_dst=1 when opcode=000000 else 0; next FETCH.
REQ-012 MEM_ADDR: alu_src_a=1, alu_src_b=10, ext_op=1, alu_op=000; next MEM_RD for lw, MEM_WR for sw.
REQ-013 MEM_RD: mem_rd=1, iord=1; next WB_MEM on mem_ready. MEM_WR: mem_wr=1, iord=1; next FETCH on mem_ready.
REQ-014 WB_MEM: reg_we=1, mem_to_reg=1, reg_dst=0; next FETCH.
REQ-015 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=100, pc_src=01, pc_we=zero; next FETCH.
REQ-016 JUMP: pc_src=10, pc_we=1; next FETCH.
REQ-017 Wait counter (8-bit):
- Clears on entry to FETCH, MEM_RD and MEM_WR, and on any cycle with mem_ready=1.
- Increments each cycle in those states while mem_ready=0.
REQ-018 Timeout: when the counter equals MEM_TIMEOUT with mem_ready=0, bus_err=1 for that cycle and the next state is FETCH. The instruction is abandoned; no reg_we or pc_we is asserted for it.
REQ-019 mem_ready has no effect outside FETCH, MEM_RD and MEM_WR.
REQ-020 Latency, zero wait states: R-type, I-type and sw take 4 cycles; beq and j take 3; lw takes 5. Each wait cycle adds 1.

Reset
REQ-021 rst_n=0 forces state=IDLE and clears the wait counter immediately, independent of clk; all outputs are 0 while rst_n=0.
REQ-022 Reset asserted mid-access drops mem_rd/mem_wr combinationally. After release the FSM spends one cycle in IDLE before FETCH.

Structure
REQ-023 A shared package holds: state encodings, the alu_op codes (matching the ALU's op field), the opcode and funct constants, and the alu_src_b and pc_src codes.
REQ-024 The FSM and wait counter live in one module; an optional combinational sub-module, alu_op_dec, maps funct/opcode to alu_op.

Verification
REQ-025 Reset release, mem_ready=1, instr=addu (funct 100001) -> states 0,1,2,3,5,1; alu_op=000 in EXE_R; reg_we=1, reg_dst=1 in WB.
REQ-026 beq with zero=1 -> pc_we=1, pc_src=01 in BRANCH; repeat with zero=0 -> pc_we=0.
REQ-027 lw with mem_ready low for 3 cycles in MEM_RD -> 8-cycle instruction; mem_to_reg=1, reg_we=1 in WB_MEM.
REQ-028 sw with mem_ready held low, MEM_TIMEOUT=4 -> bus_err pulses on the 5th MEM_WR cycle; next state FETCH; no reg_we.
REQ-029 Opcode 111111 -> illegal=1 in DECODE, then FETCH; reg_we and pc_we stay 0.
REQ-030 rst_n low during MEM_WR -> mem_wr=0 in the same cycle; state=0; the first FETCH follows 2 clocks after release.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl_pkg
// Shared definitions for the multicycle datapath controller:
//   - state_t        : FSM state encoding (also visible on the debug port)
//   - ALU_*          : ALU operation codes, identical to the ALU op field
//   - OP_* / F_*     : instruction opcode and R-type funct constants
//   - SRCB_*         : ALU B-operand mux select codes
//   - PCSRC_*        : PC source mux select codes
// -----------------------------------------------------------------------------
package multicycle_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_FETCH    = 4'd1,
        S_DECODE   = 4'd2,
        S_EXE_R    = 4'd3,
        S_EXE_I    = 4'd4,
        S_WB       = 4'd5,
        S_MEM_ADDR = 4'd6,
        S_MEM_RD   = 4'd7,
        S_MEM_WR   = 4'd8,
        S_WB_MEM   = 4'd9,
        S_BRANCH   = 4'd10,
        S_JUMP     = 4'd11
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b100;
    localparam logic [2:0] ALU_AND = 3'b001;
    localparam logic [2:0] ALU_OR  = 3'b101;
    localparam logic [2:0] ALU_XOR = 3'b010;
    localparam logic [2:0] ALU_LUI = 3'b110;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] F_ADDU = 6'b100001;
    localparam logic [5:0] F_SUBU = 6'b100011;
    localparam logic [5:0] F_AND  = 6'b100100;
    localparam logic [5:0] F_OR   = 6'b100101;
    localparam logic [5:0] F_XOR  = 6'b100110;

    localparam logic [1:0] SRCB_REG     = 2'b00;
    localparam logic [1:0] SRCB_FOUR    = 2'b01;
    localparam logic [1:0] SRCB_IMM     = 2'b10;
    localparam logic [1:0] SRCB_IMM_SL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

// File: rtl/multicycle_ctrl_alu_op_dec.sv
// -----------------------------------------------------------------------------
// alu_op_dec
// Combinational mapping from opcode/funct to the ALU operation and the
// immediate extension mode.
//   i_opcode [5:0] : instruction opcode
//   i_funct  [5:0] : R-type funct field
//   o_alu_op [2:0] : ALU operation code
//   o_ext_op       : 1 sign-extend, 0 zero-extend (meaningful for I-type only)
//   o_valid        : opcode/funct pair is a supported ALU instruction
// -----------------------------------------------------------------------------
module alu_op_dec
    import multicycle_ctrl_pkg::*;
(
    input  logic [5:0] i_opcode,
    input  logic [5:0] i_funct,
    output logic [2:0] o_alu_op,
    output logic       o_ext_op,
    output logic       o_valid
);

    always_comb begin
        o_alu_op = ALU_ADD;
        o_ext_op = 1'b1;
        o_valid  = 1'b0;
        case (i_opcode)
            OP_RTYPE: begin
                o_valid = 1'b1;
                case (i_funct)
                    F_ADDU:  o_alu_op = ALU_ADD;
                    F_SUBU:  o_alu_op = ALU_SUB;
                    F_AND:   o_alu_op = ALU_AND;
                    F_OR:    o_alu_op = ALU_OR;
                    F_XOR:   o_alu_op = ALU_XOR;
                    default: o_valid  = 1'b0;
                endcase
            end
            OP_ADDIU: begin
                o_alu_op = ALU_ADD;
                o_valid  = 1'b1;
            end
            OP_ORI: begin
                o_alu_op = ALU_OR;
                o_ext_op = 1'b0;
                o_valid  = 1'b1;
            end
            OP_LUI: begin
                o_alu_op = ALU_LUI;
                o_ext_op = 1'b0;
                o_valid  = 1'b1;
            end
            default: begin
                o_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
// Moore control FSM for a multicycle MIPS-like datapath with a memory wait
// counter that abandons an access after MEM_TIMEOUT consecutive not-ready
// cycles.
//   clk, rst_n        : rising-edge clock, asynchronous active-low reset
//   instr [31:0]      : instruction register contents (valid from DECODE)
//   zero              : ALU zero flag (gates pc_we in BRANCH)
//   mem_ready         : memory completes the access this cycle
//   pc_we, pc_src     : PC write enable / source select
//   ir_we             : instruction register write enable
//   iord              : memory address select (0 PC, 1 ALUOut)
//   mem_rd, mem_wr    : memory strobes
//   reg_we, reg_dst   : register-file write enable / destination select
//   mem_to_reg        : write-back source (1 MDR, 0 ALUOut)
//   alu_src_a/b       : ALU operand selects
//   ext_op, alu_op    : immediate extension mode / ALU operation
//   illegal, bus_err  : one-cycle error pulses
//   state [3:0]       : current FSM state (debug)
// Handshake: mem_ready is sampled only in FETCH, MEM_RD and MEM_WR; a cycle in
// one of those states with mem_ready=1 completes the access and the FSM moves
// on at the next rising edge; mem_ready=0 keeps the FSM in place until the
// wait counter reaches MEM_TIMEOUT.
// -----------------------------------------------------------------------------
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_we,
    output logic [1:0]  pc_src,
    output logic        ir_we,
    output logic        iord,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic        reg_we,
    output logic        reg_dst,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        ext_op,
    output logic [2:0]  alu_op,
    output logic        illegal,
    output logic        bus_err,
    output logic [3:0]  state
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t     r_state;
    state_t     w_next;
    logic [7:0] r_wait_cnt;

    logic [5:0] w_opcode;
    logic [5:0] w_funct;
    logic [2:0] w_dec_alu_op;
    logic       w_dec_ext_op;
    logic       w_dec_valid;
    logic       w_mem_state;
    logic       w_timeout;
    logic       w_unused_instr;

    assign w_opcode       = instr[31:26];
    assign w_funct        = instr[5:0];
    assign w_unused_instr = ^instr[25:6];
    assign state          = r_state;

    alu_op_dec u_alu_op_dec (
        .i_opcode (w_opcode),
        .i_funct  (w_funct),
        .o_alu_op (w_dec_alu_op),
        .o_ext_op (w_dec_ext_op),
        .o_valid  (w_dec_valid)
    );

    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                         (r_state == S_MEM_WR);
    assign w_timeout   = w_mem_state && !mem_ready && (r_wait_cnt == TIMEOUT_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The counter is zero on the first cycle of every memory state: a state
    // change (or a timeout re-entering FETCH) clears it, as does any
    // completed access. Outside the memory states it simply rests at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= 8'd0;
        end else if (!w_mem_state || mem_ready || w_timeout || (w_next != r_state)) begin
            r_wait_cnt <= 8'd0;
        end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
        end
    end

    always_comb begin
        w_next     = r_state;
        pc_we      = 1'b0;
        pc_src     = PCSRC_ALU;
        ir_we      = 1'b0;
        iord       = 1'b0;
        mem_rd     = 1'b0;
        mem_wr     = 1'b0;
        reg_we     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_REG;
        ext_op     = 1'b0;
        alu_op     = ALU_ADD;
        illegal    = 1'b0;
        bus_err    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next = S_FETCH;
            end
            S_FETCH: begin
                mem_rd    = 1'b1;
                alu_src_b = SRCB_FOUR;
                ir_we     = mem_ready;
                pc_we     = mem_ready;
                if (w_timeout) begin
                    bus_err = 1'b1;
                    w_next  = S_FETCH;
                end else if (mem_ready) begin
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target is computed here so BRANCH can use ALUOut.
                alu_src_b = SRCB_IMM_SL2;
                ext_op    = 1'b1;
                case (w_opcode)
                    OP_RTYPE:                 w_next = S_EXE_R;
                    OP_ADDIU, OP_ORI, OP_LUI: w_next = S_EXE_I;
                    OP_LW, OP_SW:             w_next = S_MEM_ADDR;
                    OP_BEQ:                   w_next = S_BRANCH;
                    OP_J:                     w_next = S_JUMP;
                    default: begin
                        illegal = 1'b1;
                        w_next  = S_FETCH;
                    end
                endcase
            end
            S_EXE_R: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                if (w_dec_valid) begin
                    alu_op = w_dec_alu_op;
                    w_next = S_WB;
                end else begin
                    illegal = 1'b1;
                    w_next  = S_FETCH;
                end
            end
            S_EXE_I: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                alu_op    = w_dec_alu_op;
                ext_op    = w_dec_ext_op;
                w_next    = S_WB;
            end
            S_WB: begin
                reg_we  = 1'b1;
                reg_dst = (w_opcode == OP_RTYPE);
                w_next  = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_IMM;
                ext_op    = 1'b1;
                w_next    = (w_opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_rd = 1'b1;
                iord   = 1'b1;
                if (w_timeout) begin
                    bus_err = 1'b1;
                    w_next  = S_FETCH;
                end else if (mem_ready) begin
                    w_next = S_WB_MEM;
                end
            end
            S_MEM_WR: begin
                mem_wr = 1'b1;
                iord   = 1'b1;
                if (w_timeout) begin
                    bus_err = 1'b1;
                    w_next  = S_FETCH;
                end else if (mem_ready) begin
                    w_next = S_FETCH;
                end
            end
            S_WB_MEM: begin
                reg_we     = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_src_b = SRCB_REG;
                alu_op    = ALU_SUB;
                pc_src    = PCSRC_ALUOUT;
                pc_we     = zero;
                w_next    = S_FETCH;
            end
            S_JUMP: begin
                pc_src = PCSRC_JUMP;
                pc_we  = 1'b1;
                w_next = S_FETCH;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
// Each instruction is expanded by a reference model into its per-cycle trace
// (expected outputs plus the instr/mem_ready/zero to drive in that cycle).
// The driver replays the trace one clock at a time and compares the full
// output vector at the falling edge.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    localparam int TMO = 4;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        pc_we, ir_we, iord, mem_rd, mem_wr, reg_we, reg_dst, mem_to_reg;
    logic        alu_src_a, ext_op, illegal, bus_err;
    logic [1:0]  pc_src, alu_src_b;
    logic [2:0]  alu_op;
    logic [3:0]  state;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .pc_we(pc_we), .pc_src(pc_src), .ir_we(ir_we), .iord(iord),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_we(reg_we), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .ext_op(ext_op), .alu_op(alu_op), .illegal(illegal), .bus_err(bus_err),
        .state(state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pc_we;
        logic [1:0] pc_src;
        logic       ir_we;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       reg_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic       ext_op;
        logic [2:0] alu_op;
        logic       illegal;
        logic       bus_err;
    } ov_t;

    logic [22:0] obs;
    assign obs = {state, pc_we, pc_src, ir_we, iord, mem_rd, mem_wr, reg_we, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, ext_op, alu_op, illegal, bus_err};

    // ---------------- scoreboard ----------------
    logic [22:0] exp_q[$];
    logic [33:0] drv_q[$];
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [22:0] e);
        checks++;
        assert (obs === e) else begin
            errors++;
            $error("FAIL %s check#%0d got %h exp %h", tag, checks, obs, e);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic ov_t blank(input logic [3:0] st);
        ov_t o;
        o = '0;
        o.st = st;
        return o;
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] fn);
        return {op, 20'($urandom), fn};
    endfunction

    task automatic push(input ov_t o, input logic [31:0] ins, input logic mr, input logic z);
        exp_q.push_back(o);
        drv_q.push_back({ins, mr, z});
    endtask

    // One memory access: nw not-ready cycles, then a ready cycle. If nw
    // exceeds the timeout, the access is cut after TMO+1 cycles with bus_err.
    // Returns 1 when the access completed.
    task automatic mem_phase(input ov_t base, input logic [31:0] ins, input int nw,
                             input logic is_fetch, output logic done);
        ov_t o;
        for (int i = 0; i < nw && i <= TMO; i++) begin
            o = base;
            o.bus_err = (i == TMO);
            push(o, ins, 1'b0, rb());
        end
        done = (nw <= TMO);
        if (done) begin
            o = base;
            o.ir_we = is_fetch;
            o.pc_we = is_fetch;
            push(o, ins, 1'b1, rb());
        end
    endtask

    task automatic gen(input logic [31:0] ins, input int fw, input int mw, input logic z);
        ov_t o;
        logic done;
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        o = blank(4'd1);
        o.mem_rd = 1'b1;
        o.alu_src_b = 2'b01;
        mem_phase(o, ins, fw, 1'b1, done);
        if (!done) return;
        o = blank(4'd2);
        o.alu_src_b = 2'b11;
        o.ext_op = 1'b1;
        if (!(op inside {6'h00, 6'h09, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02})) begin
            o.illegal = 1'b1;
            push(o, ins, rb(), rb());
            return;
        end
        push(o, ins, rb(), rb());
        case (op)
            6'h00: begin
                o = blank(4'd3);
                o.alu_src_a = 1'b1;
                case (fn)
                    6'h21: o.alu_op = 3'b000;
                    6'h23: o.alu_op = 3'b100;
                    6'h24: o.alu_op = 3'b001;
                    6'h25: o.alu_op = 3'b101;
                    6'h26: o.alu_op = 3'b010;
                    default: o.illegal = 1'b1;
                endcase
                push(o, ins, rb(), rb());
                if (o.illegal) return;
                o = blank(4'd5);
                o.reg_we = 1'b1;
                o.reg_dst = 1'b1;
                push(o, ins, rb(), rb());
            end
            6'h09, 6'h0d, 6'h0f: begin
                o = blank(4'd4);
                o.alu_src_a = 1'b1;
                o.alu_src_b = 2'b10;
                o.ext_op = (op == 6'h09);
                o.alu_op = (op == 6'h09) ? 3'b000 : (op == 6'h0d) ? 3'b101 : 3'b110;
                push(o, ins, rb(), rb());
                o = blank(4'd5);
                o.reg_we = 1'b1;
                push(o, ins, rb(), rb());
            end
            6'h23, 6'h2b: begin
                o = blank(4'd6);
                o.alu_src_a = 1'b1;
                o.alu_src_b = 2'b10;
                o.ext_op = 1'b1;
                push(o, ins, rb(), rb());
                o = blank((op == 6'h23) ? 4'd7 : 4'd8);
                o.iord = 1'b1;
                o.mem_rd = (op == 6'h23);
                o.mem_wr = (op == 6'h2b);
                mem_phase(o, ins, mw, 1'b0, done);
                if (done && op == 6'h23) begin
                    o = blank(4'd9);
                    o.reg_we = 1'b1;
                    o.mem_to_reg = 1'b1;
                    push(o, ins, rb(), rb());
                end
            end
            6'h04: begin
                o = blank(4'd10);
                o.alu_src_a = 1'b1;
                o.alu_op = 3'b100;
                o.pc_src = 2'b01;
                o.pc_we = z;
                push(o, ins, rb(), z);
            end
            default: begin
                o = blank(4'd11);
                o.pc_src = 2'b10;
                o.pc_we = 1'b1;
                push(o, ins, rb(), rb());
            end
        endcase
    endtask

    function automatic logic [31:0] rand_instr();
        logic [5:0] fl [0:4];
        logic [5:0] ops [0:7];
        fl  = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26};
        ops = '{6'h09, 6'h0d, 6'h0f, 6'h23, 6'h2b, 6'h04, 6'h02, 6'h02};
        case ($urandom_range(0, 3))
            0:       return mk(6'h00, fl[$urandom_range(0, 4)]);
            1:       return mk(6'($urandom), 6'($urandom));
            default: return mk(ops[$urandom_range(0, 7)], 6'($urandom));
        endcase
    endfunction

    // ---------------- driver ----------------
    task automatic run_trace(input int n);
        logic [33:0] d;
        logic [22:0] e;
        for (int k = 0; k < n && exp_q.size() > 0; k++) begin
            d = drv_q.pop_front();
            e = exp_q.pop_front();
            instr     = d[33:2];
            mem_ready = d[1];
            zero      = d[0];
            @(negedge clk);
            check("trace", e);
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        ov_t o;
        int fw;
        rst_n     = 1'b0;
        instr     = 32'hffff_ffff;
        mem_ready = 1'b1;
        zero      = 1'b1;
        #3;
        check("reset_a", 23'd0);
        @(posedge clk);
        #2;
        instr = 32'h8c00_0000;
        check("reset_b", 23'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push(blank(4'd0), $urandom, rb(), rb());

        gen(mk(6'h00, 6'h21), 0, 0, 1'b0);          // addu: 0,1,2,3,5,1
        gen(mk(6'h04, 6'h00), 0, 0, 1'b1);          // beq taken
        gen(mk(6'h04, 6'h00), 0, 0, 1'b0);          // beq not taken
        gen(mk(6'h23, 6'h00), 0, 3, 1'b0);          // lw with 3 wait cycles
        gen(mk(6'h2b, 6'h00), 0, TMO + 1, 1'b0);    // sw timeout
        gen(mk(6'h3f, 6'h00), 0, 0, 1'b0);          // illegal opcode
        gen(mk(6'h00, 6'h00), 0, 0, 1'b0);          // illegal funct
        gen(mk(6'h09, 6'h00), TMO + 1, 0, 1'b0);    // fetch timeout
        gen(mk(6'h0d, 6'h00), TMO, 0, 1'b0);        // ready just at the limit
        gen(mk(6'h0f, 6'h00), 0, 0, 1'b0);
        gen(mk(6'h02, 6'h00), 0, 0, 1'b0);
        gen(mk(6'h2b, 6'h00), 1, TMO, 1'b0);
        run_trace(100000);

        // Reset asserted in the middle of a store.
        gen(mk(6'h2b, 6'h00), 0, 2, 1'b0);
        run_trace(3);
        instr     = drv_q[0][33:2];
        mem_ready = 1'b0;
        #1;
        o = blank(4'd8);
        o.mem_wr = 1'b1;
        o.iord = 1'b1;
        check("memwr_pre", o);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async", 23'd0);
        exp_q.delete();
        drv_q.delete();
        @(posedge clk);
        #1;
        check("rst_hold", 23'd0);
        rst_n = 1'b1;
        push(blank(4'd0), $urandom, rb(), rb());

        for (int n = 0; n < 150; n++) begin
            fw = ($urandom_range(0, 9) == 0) ? TMO + 1 : $urandom_range(0, 2);
            gen(rand_instr(), fw, $urandom_range(0, TMO + 1), rb());
        end
        run_trace(100000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
